// File: rtl/pov_pkg.sv
// rtl/pov_pkg.sv - shared rotor tracking types and width helpers
package pov_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } rotor_state_t;

  localparam int DEFAULT_ROTATIONAL_RES = 1024;
  localparam int THETA_W = $clog2(DEFAULT_ROTATIONAL_RES);

  function automatic int theta_width(input int res);
    return $clog2(res);
  endfunction

endpackage

// File: rtl/period_estimator.sv
// rtl/period_estimator.sv - segment cycle counter, stall strobe, IIR period estimate (ROTOR_GLITCH_REJECT_EN)
module period_estimator
  import pov_pkg::*;
#(
  parameter int PERIOD_W     = 24,
  parameter int STALL_CYCLES = 12_000_000,
  parameter int AVG_SHIFT    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mark,
  input  rotor_state_t        state,
  output logic [PERIOD_W-1:0] period_est,
  output logic                stall,
  output logic                reject
);

  localparam logic [PERIOD_W-1:0] CNT_MAX  = '1;
  localparam logic [PERIOD_W-1:0] ONE      = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] STALL_AT = PERIOD_W'(STALL_CYCLES);

  logic [PERIOD_W-1:0] seg_cnt;
  logic [PERIOD_W-1:0] seg_nxt;
  logic [PERIOD_W-1:0] measured;
  logic [PERIOD_W-1:0] smoothed;
  logic signed [PERIOD_W:0] diff;
  logic signed [PERIOD_W:0] delta;
  logic signed [PERIOD_W:0] sum;

  // The measured period counts the current cycle, so marks N cycles apart measure N
  always_comb begin
    seg_nxt  = (seg_cnt == CNT_MAX) ? seg_cnt : seg_cnt + ONE;
    measured = (seg_nxt == '0) ? ONE : seg_nxt;
    diff     = $signed({1'b0, measured}) - $signed({1'b0, period_est});
    delta    = diff >>> AVG_SHIFT;
    sum      = $signed({1'b0, period_est}) + delta;
    smoothed = (sum[PERIOD_W] || (sum[PERIOD_W-1:0] == '0)) ? ONE : sum[PERIOD_W-1:0];
    stall    = !mark && (seg_nxt == STALL_AT);
  end

`ifdef ROTOR_GLITCH_REJECT_EN
  assign reject = (state == LOCKED) && (seg_cnt < (period_est >> 1));
`else
  assign reject = 1'b0;
`endif

  // Segment counter restarts on accepted marks; estimate loads on lock, smooths while locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_cnt    <= '0;
      period_est <= '0;
    end else begin
      seg_cnt <= mark ? '0 : seg_nxt;
      if (mark && (state == ACQUIRE)) begin
        period_est <= measured;
      end else if (mark && (state == LOCKED)) begin
        period_est <= smoothed;
      end
    end
  end

endmodule

// File: rtl/rotor_angle_tracker.sv
// rtl/rotor_angle_tracker.sv - IR index marks to interpolated rotor angle (option ROTOR_GLITCH_REJECT_EN)
module rotor_angle_tracker
  import pov_pkg::*;
#(
  parameter int ROTATIONAL_RES = 1024,
  parameter int NUM_MARKERS    = 1,
  parameter int PERIOD_W       = 24,
  parameter int STALL_CYCLES   = 12_000_000,
  parameter int AVG_SHIFT      = 2
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              ir_tripped,
  output logic [$clog2(ROTATIONAL_RES)-1:0] theta,
  output logic                              theta_step,
  output logic                              theta_valid,
  output logic [PERIOD_W-1:0]               period_est,
  output logic                              locked,
  output logic                              stalled
);

  localparam int TW  = theta_width(ROTATIONAL_RES);
  localparam int SEG = ROTATIONAL_RES / NUM_MARKERS;
  localparam int MW  = (NUM_MARKERS > 1) ? $clog2(NUM_MARKERS) : 1;
  localparam int AW  = PERIOD_W + 1;
  localparam logic [AW:0]   RES_INC  = (AW + 1)'(ROTATIONAL_RES);
  localparam logic [MW-1:0] LAST_IDX = MW'(NUM_MARKERS - 1);

  rotor_state_t  state;
  rotor_state_t  state_nxt;
  logic          ir_q;
  logic          ir_q_prev;
  logic          mark_raw;
  logic          mark;
  logic          stall;
  logic          reject;
  logic [MW-1:0] mark_idx;
  logic [MW-1:0] idx_nxt;
  logic [AW-1:0] acc;
  logic [AW:0]   acc_sum;
  logic [TW-1:0] mark_theta;
  logic [TW-1:0] seg_last;
  logic          at_seg_end;
  logic          step_due;

  period_estimator #(
    .PERIOD_W    (PERIOD_W),
    .STALL_CYCLES(STALL_CYCLES),
    .AVG_SHIFT   (AVG_SHIFT)
  ) u_period (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .mark      (mark),
    .state     (state),
    .period_est(period_est),
    .stall     (stall),
    .reject    (reject)
  );

  // Register the sensor once, keep the previous sample for rising-edge detection
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ir_q      <= 1'b0;
      ir_q_prev <= 1'b0;
    end else begin
      ir_q      <= ir_tripped;
      ir_q_prev <= ir_q;
    end
  end

  // Mark qualification, segment bounds and phase accumulator compare
  always_comb begin
    mark_raw   = ir_q & ~ir_q_prev;
    mark       = mark_raw & ~reject;
    idx_nxt    = (mark_idx == LAST_IDX) ? '0 : mark_idx + MW'(1);
    mark_theta = TW'(int'(idx_nxt) * SEG);
    seg_last   = TW'((int'(mark_idx) + 1) * SEG - 1);
    at_seg_end = (theta == seg_last);
    acc_sum    = {1'b0, acc} + RES_INC;
    step_due   = (acc_sum >= {2'b00, period_est});
  end

  // Lock progression: each mark moves one state toward LOCKED, a stall drops back
  always_comb begin
    state_nxt = state;
    if (mark) begin
      case (state)
        UNLOCKED: state_nxt = ACQUIRE;
        ACQUIRE:  state_nxt = LOCKED;
        LOCKED:   state_nxt = LOCKED;
        default:  state_nxt = UNLOCKED;
      endcase
    end else if (stall) begin
      state_nxt = UNLOCKED;
    end
  end

  // State register and sticky stall flag; an accepted mark takes priority over stall
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= UNLOCKED;
      stalled <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mark) begin
        stalled <= 1'b0;
      end else if (stall) begin
        stalled <= 1'b1;
      end
    end
  end

  // Theta snaps to the segment base on marks, otherwise steps while LOCKED up to the segment end
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      theta      <= '0;
      theta_step <= 1'b0;
      acc        <= '0;
      mark_idx   <= '0;
    end else if (mark) begin
      mark_idx   <= idx_nxt;
      theta      <= mark_theta;
      theta_step <= (mark_theta != theta);
      acc        <= '0;
    end else if ((state == LOCKED) && !at_seg_end) begin
      if (step_due) begin
        theta      <= theta + TW'(1);
        acc        <= AW'(acc_sum - {2'b00, period_est});
        theta_step <= 1'b1;
      end else begin
        acc        <= acc_sum[AW-1:0];
        theta_step <= 1'b0;
      end
    end else begin
      theta_step <= 1'b0;
    end
  end

  assign locked      = (state == LOCKED);
  assign theta_valid = locked;

endmodule
